// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes PS/2 Set-2 scan-code bytes (E0 extended, F0 break prefixes)
// for 17 game keys. It keeps a live held-key bitmap and queues press/release events in a
// small FIFO with a valid/ready output.
// Optional build macro: TYPEMATIC_FILTER_EN. When it is defined, auto-repeat makes and
// breaks of keys that are not held push no event.
module ps2_key_tracker #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned PREFIX_TIMEOUT = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [7:0]  code_byte,
    input  logic        code_err,
    output logic [16:0] key_held,
    output logic        event_valid,
    output logic [4:0]  event_key,
    output logic        event_press,
    input  logic        event_ready,
    output logic        overflow
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(PREFIX_TIMEOUT - 1);
    localparam logic [CW-1:0] FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e          r_state, w_state_d;
    logic [TW-1:0]   r_tmo_cnt, w_tmo_cnt_d;
    logic            w_resolve, w_ext, w_make, w_is_prefix;
    logic            w_hit;
    logic [4:0]      w_idx;
    logic            w_push, w_push_ok, w_pop, w_full;
    logic [5:0]      w_push_data;
    logic [16:0]     r_key_held;
    logic            r_overflow, r_event_valid;
    logic [5:0]      r_head, w_head_d;
    logic [5:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_d;
    logic [CW-1:0]   r_count, w_count_d, w_after_pop;

    // Returns {hit, index}; the extended flag must match exactly for a hit.
    function automatic logic [5:0] map_key(input logic ext, input logic [7:0] code);
        logic [5:0] res;
        res = 6'd0;
        if (ext) begin
            case (code)
                8'h75:   res = {1'b1, 5'd0};
                8'h72:   res = {1'b1, 5'd1};
                8'h6B:   res = {1'b1, 5'd2};
                8'h74:   res = {1'b1, 5'd3};
                default: res = 6'd0;
            endcase
        end else begin
            case (code)
                8'h1D:   res = {1'b1, 5'd4};
                8'h1C:   res = {1'b1, 5'd5};
                8'h1B:   res = {1'b1, 5'd6};
                8'h23:   res = {1'b1, 5'd7};
                8'h35:   res = {1'b1, 5'd8};
                8'h34:   res = {1'b1, 5'd9};
                8'h33:   res = {1'b1, 5'd10};
                8'h3B:   res = {1'b1, 5'd11};
                8'h4D:   res = {1'b1, 5'd12};
                8'h4B:   res = {1'b1, 5'd13};
                8'h4C:   res = {1'b1, 5'd14};
                8'h52:   res = {1'b1, 5'd15};
                8'h29:   res = {1'b1, 5'd16};
                default: res = 6'd0;
            endcase
        end
        return res;
    endfunction

    assign w_is_prefix    = (code_byte == 8'hE0) || (code_byte == 8'hF0);
    assign {w_hit, w_idx} = map_key(w_ext, code_byte);

    // Decoder next state and resolution; an accepted byte wins over a same-cycle timeout.
    always_comb begin
        w_state_d = r_state;
        w_resolve = 1'b0;
        w_ext     = 1'b0;
        w_make    = 1'b0;
        if (code_valid && code_err) begin
            w_state_d = StIdle;
        end else if (code_valid) begin
            unique case (r_state)
                StIdle: begin
                    if (code_byte == 8'hE0) begin
                        w_state_d = StExt;
                    end else if (code_byte == 8'hF0) begin
                        w_state_d = StBrk;
                    end else if (code_byte != 8'hE1) begin
                        w_resolve = 1'b1;
                        w_make    = 1'b1;
                    end
                end
                StExt: begin
                    if (code_byte == 8'hF0) begin
                        w_state_d = StExtBrk;
                    end else if (code_byte == 8'hE0) begin
                        w_state_d = StExt;
                    end else begin
                        w_resolve = 1'b1;
                        w_make    = 1'b1;
                        w_ext     = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                StBrk: begin
                    w_state_d = StIdle;
                    w_resolve = !w_is_prefix;
                end
                StExtBrk: begin
                    w_state_d = StIdle;
                    w_resolve = !w_is_prefix;
                    w_ext     = 1'b1;
                end
                default: w_state_d = StIdle;
            endcase
        end else if ((r_state != StIdle) && (r_tmo_cnt == TLAST)) begin
            w_state_d = StIdle;
        end
        w_tmo_cnt_d = ((w_state_d == StIdle) || code_valid) ? '0 : r_tmo_cnt + TW'(1);
    end

    // Decoder state and prefix timeout counter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state   <= StIdle;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_d;
            r_tmo_cnt <= w_tmo_cnt_d;
        end
    end

    // FIFO push/pop control and next head entry.
    always_comb begin
`ifdef TYPEMATIC_FILTER_EN
        w_push = w_resolve && w_hit && (w_make != r_key_held[w_idx]);
`else
        w_push = w_resolve && w_hit;
`endif
        w_push_data = {w_idx, w_make};
        w_full      = (r_count == FULL);
        w_pop       = r_event_valid && event_ready;
        w_push_ok   = w_push && (!w_full || w_pop);
        w_after_pop = r_count - CW'(w_pop);
        w_count_d   = w_after_pop + CW'(w_push_ok);
        w_rd_ptr_d  = r_rd_ptr + AW'(w_pop);
        w_head_d    = r_head;
        if (w_count_d != '0) begin
            // If nothing remains after the pop, the new head is the entry pushed now.
            w_head_d = (w_after_pop == '0) ? w_push_data : r_mem[w_rd_ptr_d];
        end
    end

    // FIFO storage needs no reset; occupancy gates every read.
    always_ff @(posedge CLOCK_50) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Held bitmap, FIFO pointers, registered head outputs and sticky overflow.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_key_held    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_event_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_resolve && w_hit) begin
                r_key_held[w_idx] <= w_make;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
            r_rd_ptr      <= w_rd_ptr_d;
            r_count       <= w_count_d;
            r_head        <= w_head_d;
            r_event_valid <= (w_count_d != '0);
        end
    end

    assign key_held    = r_key_held;
    assign event_valid = r_event_valid;
    assign event_key   = r_head[5:1];
    assign event_press = r_head[0];
    assign overflow    = r_overflow;

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits directly downstream of the PS/2 keyboard receiver. Consumes its validated 8-bit scan-code bytes.
- Decodes PS/2 Set-2 prefix sequences (E0 extended, F0 break) for the 17 game keys.
- Maintains a live held-key bitmap for game logic. Queues press/release events in a small FIFO with a valid/ready output handshake.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..32.
- PREFIX_TIMEOUT, 50000, CLOCK_50 cycles a prefix state waits for its next byte before it is abandoned (1 ms).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code_byte is valid this cycle.
- code_byte  in  8  received scan-code byte.
- code_err  in  1  qualifies code_valid; byte failed start/stop/parity check.
- key_held  out  17  bit i = game key i currently held.
- event_valid  out  1  FIFO non-empty; head event presented.
- event_key  out  5  key index of head event (0..16).
- event_press  out  1  1 = make (press), 0 = break (release).
- event_ready  in  1  consumer accepts the head when event_valid && event_ready.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset: key_held = 0, event_valid = 0, event_key = 0, event_press = 0, overflow = 0, FIFO emptied, decoder state = IDLE, timeout counter = 0. Reset mid-sequence discards any partial prefix.

Key index map (prefix + code):
- 0 up E0 75; 1 down E0 72; 2 left E0 6B; 3 right E0 74
- 4 W 1D; 5 A 1C; 6 S 1B; 7 D 23
- 8 Y 35; 9 G 34; 10 H 33; 11 J 3B
- 12 P 4D; 13 L 4B; 14 ; 4C; 15 ' 52; 16 space 29
- Matching is strict:
  - Non-E0 75/72/6B/74 (keypad keys) is ignored.
  - E0 with a letter code is ignored.

Decoder FSM (advances only on code_valid && !code_err):
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> IDLE, byte ignored.
  - Any other byte: resolve as make (non-extended), stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> EXT.
  - Other byte: resolve as make (extended) -> IDLE.
- BRK: any byte except E0/F0 resolves as break (non-extended) -> IDLE. E0/F0 -> IDLE, dropped.
- EXT_BRK: any byte except E0/F0 resolves as break (extended) -> IDLE. E0/F0 -> IDLE, dropped.

Error and timeout handling:
- code_valid && code_err: byte discarded; FSM -> IDLE from any state.
- Timeout counter runs only in EXT/BRK/EXT_BRK and clears on any accepted byte. At PREFIX_TIMEOUT-1 the FSM -> IDLE and the counter clears.

Resolution of a mapped key k:
- Make sets key_held[k]. Break clears key_held[k].
- Both push {k, press} into the FIFO.
- Unmapped codes change nothing and push nothing.

Latency:
- key_held and the FIFO push take effect on the edge that samples the resolving byte.
- event_valid rises the following cycle when the FIFO was empty.
- Prefix bytes produce no output.

FIFO:
- Pop on event_valid && event_ready.
- Outputs show the head entry, registered.
- Empty: event_valid = 0; event_key/event_press hold their last values.
- Full with no pop: new event dropped, overflow set to 1 and held until reset; key_held still updates.
- Full with simultaneous pop: push accepted, no overflow.
- Count wraps modulo FIFO_DEPTH via pointer arithmetic; occupancy tracked in $clog2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro TYPEMATIC_FILTER_EN.
- Defined: a make for key k while key_held[k] is already 1 (keyboard auto-repeat) pushes no event; a break for a key not held pushes no event; key_held update is unchanged.
- Undefined: every resolved make/break of a mapped key pushes an event.

Test Plan:
- Bytes 1D, then F0 1D, event_ready = 1 -> key_held[4] goes 1 then 0; events {4,1}, {4,0} in order; overflow = 0.
- Bytes E0 75, then E0 F0 75 -> key_held[0] 1 then 0, events {0,1}, {0,0}. Bare 75 -> no event, key_held unchanged.
- E0 then idle for PREFIX_TIMEOUT cycles, then 1C -> FSM back to IDLE before 1C; event {5,1} (not extended, not dropped). E0 followed by an errored byte, then 29 -> event {16,1} only.
- event_ready = 0, 9 mapped makes with FIFO_DEPTH = 8 -> 8 events retained in order, overflow = 1. Then ready = 1 drains exactly 8; overflow stays 1 until reset.
- 1B repeated 3 times, then F0 1B -> 4 events without TYPEMATIC_FILTER_EN; with it, only {6,1}, {6,0}.
- Assert reset between F0 and 1D, then send 1D -> event {4,1} (make, not break); all outputs 0 the cycle after reset.
